// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   DATA_W  : width of one memory word
//   CNT_W   : width of the load-latency down-counter (covers READ_LAT up to 7)
//   state_e : responder FSM states
package dmem_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage for the data memory.
//   clk   : clock, rising edge
//   we    : write enable, commits wdata to waddr at the clock edge
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : read data; unregistered, captured by the responder's rdata register
// Contents are never reset, so they survive a responder reset.
module dmem_array #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_W    = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   mem_read  : load request
//   mem_write : store request (wins when both strobes are set)
//   addr      : word address
//   wdata     : store data
//   busy      : stall request; combinational, high while a load is in flight
//   rsp_valid : one-cycle pulse marking rdata as the load result
//   rdata     : registered load data, held between responses
//   addr_err  : sticky flag for out-of-range accesses or conflicting strobes
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int READ_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic [15:0] rdata,
  output logic        addr_err
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic                  oor_q, oor_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  addr_err_q, addr_err_d;
  logic                  busy_c;

  logic                  addr_oor;
  logic                  arr_we;
  logic [ADDR_BITS-1:0]  arr_raddr;
  logic [DATA_W-1:0]     arr_rdata;

  // Any set bit above the implemented word-address range is an error.
  assign addr_oor = (addr >> ADDR_BITS) != 16'd0;

  // Stores commit only from IDLE, only in range; a simultaneous load strobe
  // does not block the store.
  assign arr_we = (state_q == IDLE) && mem_write && !addr_oor;

  // In IDLE the live address is read (single-cycle latency case); while
  // waiting, the latched address is used.
  assign arr_raddr = (state_q == IDLE) ? addr[ADDR_BITS-1:0] : addr_q;

  dmem_array #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (addr[ADDR_BITS-1:0]),
    .wdata (wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    oor_d       = oor_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    addr_err_d  = addr_err_q;
    busy_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_write) begin
          if (addr_oor || mem_read) begin
            addr_err_d = 1'b1;
          end
        end else if (mem_read) begin
          busy_c = 1'b1;
          addr_d = addr[ADDR_BITS-1:0];
          oor_d  = addr_oor;
          if (addr_oor) begin
            addr_err_d = 1'b1;
          end
          if (READ_LAT == 1) begin
            rdata_d     = addr_oor ? '0 : arr_rdata;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            cnt_d   = CNT_W'(READ_LAT - 2);
            state_d = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        busy_c = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rdata_d     = oor_q ? '0 : arr_rdata;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end

      RESP: begin
        // The requester may still be presenting the same load this cycle;
        // going straight back to IDLE without looking at it avoids a
        // duplicate response.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      oor_q       <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      oor_q       <= oor_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Masking with rst makes the stall drop the instant reset is applied,
  // even if the requester is still presenting a load.
  assign busy      = busy_c & ~rst;
  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int READ_LAT  = 2;
  localparam int ADDR_BITS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        busy;
  logic        rsp_valid;
  logic [15:0] rdata;
  logic        addr_err;

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;
  int rsp_count = 0;
  bit started = 1'b0;

  dmem_responder #(
    .ADDR_BITS (ADDR_BITS),
    .READ_LAT  (READ_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: -1 when no load is outstanding, otherwise the number of cycles
  // since the load was accepted (response is due when it equals READ_LAT).
  logic [15:0] mdl_mem [int];
  int          m_phase = -1;
  logic [15:0] m_pend = 16'h0000;
  bit          m_pend_known = 1'b1;
  logic [15:0] m_rdata = 16'h0000;
  bit          m_rdata_known = 1'b1;
  bit          m_err = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = -1;
      m_rdata = 16'h0000;
      m_rdata_known = 1'b1;
      m_err = 1'b0;
    end else begin
      if (m_phase < 0) begin
        bit oor;
        oor = int'(addr) >= (1 << ADDR_BITS);
        if (mem_write) begin
          if (!oor) mdl_mem[int'(addr)] = wdata;
          if (oor || mem_read) m_err = 1'b1;
        end else if (mem_read) begin
          if (oor) begin
            m_err = 1'b1;
            m_pend = 16'h0000;
            m_pend_known = 1'b1;
          end else if (mdl_mem.exists(int'(addr))) begin
            m_pend = mdl_mem[int'(addr)];
            m_pend_known = 1'b1;
          end else begin
            m_pend_known = 1'b0;
          end
          m_phase = 1;
        end
      end else if (m_phase < READ_LAT) begin
        m_phase++;
      end else begin
        m_phase = -1;
      end
      if (m_phase == READ_LAT) begin
        m_rdata = m_pend;
        m_rdata_known = m_pend_known;
      end
    end
  end

  // Compare process: every cycle after the initial reset.
  initial forever begin
    @(negedge clk);
    if (started && !rst) begin
      bit exp_busy;
      exp_busy = (m_phase < 0 && mem_read && !mem_write) ||
                 (m_phase >= 1 && m_phase < READ_LAT);
      chk("cmp_busy", busy, exp_busy);
      chk("cmp_rsp_valid", rsp_valid, m_phase == READ_LAT);
      chk("cmp_addr_err", addr_err, m_err);
      if (m_rdata_known) chk("cmp_rdata", rdata, m_rdata);
    end
  end

  initial forever begin
    @(posedge clk);
    cyc_no++;
  end

  initial forever begin
    @(negedge clk);
    if (rsp_valid) rsp_count++;
  end

  // ---------------- directed stimulus ----------------
  // All tasks start just after a rising edge and return just after one.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                          input bit both, input string nm);
    mem_write = 1'b1;
    mem_read = both;
    addr = a;
    wdata = d;
    @(negedge clk);
    chk({nm, "_busy"}, busy, 1'b0);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    mem_read = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] exp,
                         input string nm, output int rsp_cyc);
    int n;
    bit got;
    got = 1'b0;
    rsp_cyc = -1;
    mem_read = 1'b1;
    mem_write = 1'b0;
    addr = a;
    for (n = 0; n <= READ_LAT + 4; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      chk({nm, "_busy_wait"}, busy, 1'b1);
    end
    if (!got) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      rsp_cyc = cyc_no;
      chk({nm, "_latency"}, n, READ_LAT);
      chk({nm, "_rdata"}, rdata, exp);
      chk({nm, "_busy_resp"}, busy, 1'b0);
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
  endtask

  initial begin
    int r1, r2, cnt0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_addr_err", addr_err, 1'b0);
    @(posedge clk);
    #1;

    // Preload and basic store/load
    do_write(16'h0000, 16'h0F0F, 1'b0, "wr_0000");
    do_write(16'h0011, 16'h1234, 1'b0, "wr_0011");
    do_write(16'h0010, 16'h00A5, 1'b0, "wr_0010");
    do_read(16'h0010, 16'h00A5, "rd_0010", r1);

    // Back-to-back loads, each held until its response
    cnt0 = rsp_count;
    do_read(16'h0010, 16'h00A5, "b2b_a", r1);
    do_read(16'h0011, 16'h1234, "b2b_b", r2);
    chk("b2b_spacing", r2 - r1, READ_LAT + 1);
    repeat (READ_LAT + 2) @(negedge clk);
    chk("b2b_no_dup", rsp_count - cnt0, 2);
    @(posedge clk);
    #1;

    // Out-of-range store and load
    do_write(16'h0100, 16'hBEEF, 1'b0, "wr_oor");
    @(negedge clk);
    chk("oor_wr_err", addr_err, 1'b1);
    @(posedge clk);
    #1;
    do_read(16'h0100, 16'h0000, "rd_oor", r1);
    do_read(16'h0000, 16'h0F0F, "rd_0000_kept", r1);
    chk("oor_err_sticky", addr_err, 1'b1);

    // Reset while the load is waiting
    mem_read = 1'b1;
    addr = 16'h0011;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_busy_before", busy, 1'b1);
    #1;
    rst = 1'b1;
    mem_read = 1'b0;
    #1;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_rsp_valid", rsp_valid, 1'b0);
    chk("rstmid_addr_err", addr_err, 1'b0);
    #1;
    rst = 1'b0;
    cnt0 = rsp_count;
    repeat (READ_LAT + 2) @(negedge clk);
    chk("rstmid_no_rsp", rsp_count - cnt0, 0);
    @(posedge clk);
    #1;
    do_read(16'h0010, 16'h00A5, "rd_after_rst", r1);

    // Both strobes: behaves as a store and flags an error
    do_write(16'h0020, 16'h5555, 1'b1, "both");
    @(negedge clk);
    chk("both_err", addr_err, 1'b1);
    @(posedge clk);
    #1;
    do_read(16'h0020, 16'h5555, "rd_0020", r1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined processor's memory stage: serves the load/store requests the datapath issues (address from the MEM-stage ALU result, store data, load/store strobes) and returns load data on the datapath's read-data input. Loads take a configurable multi-cycle latency, during which the responder raises a stall to freeze the pipeline. Stores commit in one cycle with no stall. It replaces the single-cycle combinational data RAM and sits between the MEM stage and the MEM/WB register.

## Interface
Parameters:
- ADDR_BITS, 8, implemented word-address bits; depth = 2**ADDR_BITS 16-bit words
- READ_LAT, 2, load latency in cycles, legal range 1..7

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_read  in  1  load request (MEM-stage load strobe)
- mem_write  in  1  store request (MEM-stage store strobe)
- addr  in  16  word address (MEM-stage ALU result)
- wdata  in  16  store data
- busy  out  1  stall request to the pipeline; the requester holds all inputs stable while busy=1
- rsp_valid  out  1  one-cycle pulse: rdata carries the load result
- rdata  out  16  load data to the pipeline; registered
- addr_err  out  1  sticky protocol/range error flag

## Operation
- FSM states: IDLE, RD_WAIT, RESP. A 3-bit down-counter tracks the remaining read latency.
- IDLE, mem_write=1, mem_read=0: array[addr] <= wdata at the end of the cycle. busy=0. Stay in IDLE.
- IDLE, mem_read=1, mem_write=0: the request is accepted. busy=1 combinationally in this cycle (cycle 0). addr is latched into addr_q.
  - READ_LAT=1: rdata <= array[addr]; next state RESP.
  - READ_LAT>1: next state RD_WAIT, counter <= READ_LAT-2.
- RD_WAIT: busy=1. While counter≠0, decrement. When counter=0, rdata <= array[addr_q] and go to RESP.
- RESP: busy=0, rsp_valid=1. Unconditionally return to IDLE. The still-present request is not re-accepted.
- Out of range: addr[15:ADDR_BITS]≠0.
  - Write: dropped.
  - Read: normal timing, rdata=16'h0000.
  - Both cases set addr_err.
- mem_read and mem_write both 1 in IDLE: treated as a write. No read is started and addr_err is set.
- Request deasserted while busy: this is a protocol violation. The read still completes and rsp_valid still pulses.
- rdata holds its last loaded value outside RESP.
- addr_err stays set until reset.

## Timing
- Reset values: state IDLE, busy=0, rsp_valid=0, rdata=16'h0000, addr_err=0, counter=0. Array contents are not reset.
- Load latency: the request appears in cycle 0; busy=1 in cycles 0..READ_LAT-1; rsp_valid=1 and rdata valid in cycle READ_LAT, with busy=0. The pipeline advances at the end of cycle READ_LAT.
- Back-to-back loads: the next request can be accepted in cycle READ_LAT+1. Throughput is one load per READ_LAT+1 cycles.
- Stores: zero stall cycles. A load in the next cycle to the same address returns the new data.
- busy is the only combinational path, from mem_read/mem_write/state. All other outputs are registered.
- Reset asserted mid-read: the FSM returns to IDLE and busy/rsp_valid drop immediately (asynchronously). The pending read is discarded. Array contents are retained.

## Structure
- Package dmem_pkg holds:
  - DATA_W=16
  - the state enum {IDLE, RD_WAIT, RESP}
  - the latency counter width constant
- Sub-module dmem_array: 2**ADDR_BITS x 16 array with synchronous write and a read port feeding the rdata register. It has no reset.
- Top level: FSM, counter, addr_q, range check, addr_err.

## Test plan
- Reset -> busy=0, rsp_valid=0, rdata=16'h0000, addr_err=0.
- READ_LAT=2: write 16'h00A5 to 16'h0010, then read 16'h0010 -> first: busy=0, write commits. Read: busy=1 in cycles 0–1; rsp_valid=1 in cycle 2 with rdata=16'h00A5; busy=0 in cycle 2.
- Loads to 16'h0010 and 16'h0011 (preloaded 16'h1234), each held until its response -> rsp_valid in cycles 2 and 5; rdata 16'h00A5 then 16'h1234; no duplicate response.
- ADDR_BITS=8: write 16'hBEEF to 16'h0100, then read 16'h0100 -> addr_err=1; word 16'h0000 unchanged; read returns 16'h0000 with normal latency.
- Reset pulsed during RD_WAIT -> busy and rsp_valid are 0 immediately; no response is emitted; a following read of 16'h0010 returns 16'h00A5.
- mem_read=mem_write=1, addr 16'h0020, wdata 16'h5555 -> busy=0; addr_err=1; a later read of 16'h0020 returns 16'h5555.
